multicycle_control_unit: RTL

Multi-cycle successor to the single-cycle control unit of the MIPS-style datapath. A registered state machine sequences each instruction over 3–5 cycles (fetch, decode, execute, memory, write-back). It drives every datapath mux and enable, and waits on a ready/request handshake with the shared instruction/data memory. It sits beside the register file and ALU, receives `op` from the instruction register, and flags unsupported opcodes by trapping.

---
 rtl/mc_ctrl_pkg.sv | 41 ++++
 rtl/mc_opcode_decode.sv | 28 ++
 rtl/multicycle_control_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, opcodes and mux select codes for the multi-cycle control unit
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: maps the opcode to one-hot instruction-class flags plus an illegal flag
module mc_opcode_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output logic            is_rtype,
    output logic            is_lw,
    output logic            is_sw,
    output logic            is_addi,
    output logic            is_beq,
    output logic            is_j,
    output logic            illegal
);

    // compare against each supported opcode; anything unmatched is illegal
    always_comb begin
        is_rtype = op == OP_W'(OP_RTYPE);
        is_lw    = op == OP_W'(OP_LW);
        is_sw    = op == OP_W'(OP_SW);
        is_addi  = op == OP_W'(OP_ADDI);
        is_beq   = op == OP_W'(OP_BEQ);
        is_j     = op == OP_W'(OP_J);
        illegal  = !(is_rtype || is_lw || is_sw || is_addi || is_beq || is_j);
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: registered FSM sequencing each instruction over 3-5 cycles with memory handshake
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               MemRead,
    output logic               MemToWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic [1:0]         PCSource,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               RegWrite,
    output logic               instr_done,
    output logic               illegal_op
);

    state_t     state_q, state_d;
    logic       is_sw_q, is_sw_d;
    logic [2:0] alu_op;
    logic       d_rtype, d_lw, d_sw, d_addi, d_beq, d_j, d_illegal;

    mc_opcode_decode #(.OP_W(OP_W)) u_dec (
        .op       (op),
        .is_rtype (d_rtype),
        .is_lw    (d_lw),
        .is_sw    (d_sw),
        .is_addi  (d_addi),
        .is_beq   (d_beq),
        .is_j     (d_j),
        .illegal  (d_illegal)
    );

    assign ALUOp = ALUOP_W'(alu_op);

    // state register and the lw/sw choice latched in DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    // next-state and Moore/handshake outputs; everything defaults to 0
    always_comb begin
        state_d     = state_q;
        is_sw_d     = is_sw_q;
        MemRead     = 1'b0;
        MemToWrite  = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        alu_op      = ALU_ADD;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                is_sw_d = d_sw;
                state_d = d_rtype        ? S_EXEC_R   :
                          (d_lw || d_sw) ? S_MEM_ADDR :
                          d_addi         ? S_EXEC_I   :
                          d_beq          ? S_BRANCH   :
                          d_j            ? S_JUMP     : S_TRAP;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                MemToWrite = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                alu_op  = ALU_FUNCT;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                alu_op      = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: illegal_op = 1'b1;
            default: state_d = S_RESET;
        endcase
    end

endmodule
